sync_fifo_wr_arbiter: RTL and testbench
=======================================

# sync_fifo_wr_arbiter

Round-robin write arbiter that shares one `sync_fifo` write port between `NREQ` producers. Each producer issues bursts of up to `MAX_BURST` beats. The arbiter grants one producer at a time, holds the grant for the whole burst, and stalls on FIFO `full`. It drives the FIFO `wr_en`/`din` directly and sits between the producer blocks and the FIFO instance.

## Interface

Parameters:
- `NREQ`, 4, number of requesters (2..8).
- `DWIDTH`, 16, data width; must match the FIFO's `DWIDTH`.
- `MAX_BURST`, 4, maximum beats per grant (1..16).

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req`  in  `NREQ`  per-requester request and data-valid; held while data is presented.
- `last`  in  `NREQ`  per-requester flag marking the final beat of a burst; qualified by `req`.
- `din_flat`  in  `NREQ*DWIDTH`  requester data; requester i occupies `[i*DWIDTH +: DWIDTH]`.
- `fifo_full`  in  1  FIFO full flag.
- `gnt`  out  `NREQ`  registered grant, one-hot or zero.
- `ack`  out  `NREQ`  combinational; beat accepted this cycle.
- `fifo_wr_en`  out  1  combinational FIFO write enable.
- `fifo_din`  out  `DWIDTH`  combinational data to the FIFO.
- `busy`  out  1  registered; high while in BURST.

## Operation

FSM with two states, IDLE and BURST.

Registered state:
- `owner` (`$clog2(NREQ)` bits)
- `last_owner`
- `beat_cnt` (`$clog2(MAX_BURST)+1` bits)
- `gnt`

Round-robin pick:
- Scans `req` starting at `(last_owner+1) mod NREQ`, wrapping.
- The first asserted bit wins.
- The previous owner wins again only if it is the sole requester.

IDLE:
- If any `req` bit is set: run the pick, load `owner` and `gnt`, clear `beat_cnt`, go to BURST.
- Otherwise stay in IDLE with `gnt=0`.

BURST, beat transfer:
- A transfer occurs in a cycle when `req[owner]` is high and `fifo_full` is low.
- On a transfer: `fifo_wr_en=1`, `fifo_din=din[owner]`, `ack[owner]=1`, and `beat_cnt` increments.

BURST, burst end: the burst ends in the cycle that either
- transfers a beat with `last[owner]=1`, or
- transfers a beat with `beat_cnt==MAX_BURST-1` (forced end), or
- sees `req[owner]=0` (abort, no transfer).

At burst end:
- Set `last_owner <= owner`.
- Re-arbitrate on the current-cycle `req`, masked to exclude `owner` only in the abort case.
- If a winner exists, load it and stay in BURST. Otherwise go to IDLE with `gnt <= 0`.

While `fifo_full` is high:
- No transfer occurs, `beat_cnt` holds, and the grant holds (no timeout).
- `req[owner]=0` during full still aborts.

General rules:
- `ack`, `fifo_wr_en` and `fifo_din` are zero whenever no transfer occurs.
- Non-owners never see `ack`.
- `last` from non-owners is ignored.

## Timing

- Reset (asynchronous, takes effect immediately):
  - state=IDLE, `gnt=0`, `busy=0`, `beat_cnt=0`, `owner=0`, `last_owner=NREQ-1` (so requester 0 has first priority).
  - Combinational outputs are 0.
- Reset asserted mid-burst discards the burst. The FIFO sees no further `wr_en` from the cycle reset is asserted.
- Grant latency: `req` rising in IDLE gives `gnt` one cycle later. The first beat transfers in that cycle if the FIFO is not full.
- Back-to-back bursts: zero dead cycles. The new owner's `gnt` is valid the cycle after the previous final beat.
- Throughput: one beat per cycle while not full.
- `gnt` changes only on a clock edge. `ack` follows `req`/`fifo_full` combinationally within the cycle.
- Producers must hold data and `last` stable while `req` is high and `ack` is low.

## Structure

- Package `fifo_arb_pkg` holds:
  - the state enum (IDLE=1'b0, BURST=1'b1)
  - width helper constants `OWNER_W` and `CNT_W`.
- Sub-module `rr_picker` (purely combinational):
  - inputs: `req` vector, mask, start index
  - outputs: `valid` and winner index.
  - It is instantiated once and used for both the IDLE pick and the burst-end pick.
- The top module contains the FSM, counters and the output mux.

## Test plan

1. After reset, `req=4'b1111`, all `last=1`, FIFO never full:
   - gnt sequence 0001, 0010, 0100, 1000, 0001;
   - one beat each, `fifo_wr_en` high every cycle from cycle 1.
2. `req=4'b0010`, 6 beats, `last` only on beat 6, `MAX_BURST=4`:
   - beats 1-4 are written under gnt 0010, then a forced end;
   - requester 1 is regranted with no gap, and beats 5-6 complete.
3. During a burst from requester 2, `fifo_full=1` for 3 cycles:
   - `ack`=0 and `fifo_wr_en`=0 for those 3 cycles, `gnt` holds 0100 and `beat_cnt` holds;
   - the transfer resumes the cycle `full` drops.
4. Requester 0 drops `req` after 1 of 3 beats while `req[3]=1`:
   - the abort hands the grant to requester 3 on the next cycle;
   - requester 0 gets no `ack` during the abort.
5. `rstn` pulsed low mid-burst (between edges):
   - `gnt`, `busy` and `fifo_wr_en` drop to 0 immediately;
   - after release with `req=4'b1000`, gnt=1000 one cycle later.
6. Data check with `din` for requester i = 16'hA000+i, random `req`/`last`/`full` for 2000 cycles:
   - a scoreboard confirms the FIFO write stream preserves per-requester order;
   - bursts are never interleaved, and no burst exceeds 4 beats.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Index width for n requesters; never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter width; one spare bit above the max burst index.
  function automatic int unsigned cnt_w(input int unsigned m);
    return $clog2(m) + 1;
  endfunction

  localparam int unsigned NREQ_DEF      = 4;
  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned OWNER_W       = idx_w(NREQ_DEF);
  localparam int unsigned CNT_W         = cnt_w(MAX_BURST_DEF);

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first unmasked request at or after start, wrapping.
module rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned OW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [OW-1:0]   start,
  output logic            valid,
  output logic [OW-1:0]   idx
);

  logic [NREQ-1:0] w_cand;
  logic [OW-1:0]   w_k;

  assign w_cand = req & ~mask;

  // Scan from the farthest offset down so the nearest candidate is written last and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_k   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      w_k = OW'((int'(start) + i) % int'(NREQ));
      if (w_cand[w_k]) begin
        valid = 1'b1;
        idx   = w_k;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NREQ producers.
module sync_fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = NREQ_DEF,
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        last,
  input  logic [NREQ*DWIDTH-1:0] din_flat,
  input  logic                   fifo_full,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic                   fifo_wr_en,
  output logic [DWIDTH-1:0]      fifo_din,
  output logic                   busy
);

  localparam int unsigned     OW         = idx_w(NREQ);
  localparam int unsigned     CW         = cnt_w(MAX_BURST);
  localparam logic [OW-1:0]   LAST_IDX   = OW'(NREQ - 1);
  localparam logic [CW-1:0]   FINAL_BEAT = CW'(MAX_BURST - 1);

  arb_state_e      r_state, w_state_nxt;
  logic [OW-1:0]   r_owner, w_owner_nxt;
  logic [OW-1:0]   r_last_owner, w_last_owner_nxt;
  logic [CW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;

  logic [DWIDTH-1:0] w_din [NREQ];
  logic              w_own_req;
  logic              w_xfer;
  logic              w_abort;
  logic              w_end;
  logic [OW-1:0]     w_base;
  logic [OW-1:0]     w_start;
  logic [NREQ-1:0]   w_owner_oh;
  logic [NREQ-1:0]   w_mask;
  logic              w_pick_vld;
  logic [OW-1:0]     w_pick_idx;
  logic [NREQ-1:0]   w_pick_oh;

  // Unpack the flat requester data bus.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      w_din[i] = din_flat[i*DWIDTH +: DWIDTH];
    end
  end

  assign w_owner_oh = NREQ'(1) << r_owner;
  assign w_own_req  = req[r_owner];
  assign w_xfer     = (r_state == BURST) && w_own_req && !fifo_full;
  assign w_abort    = (r_state == BURST) && !w_own_req;
  assign w_end      = w_abort || (w_xfer && (last[r_owner] || (r_beat_cnt == FINAL_BEAT)));

  // Priority starts just past the most recent owner; at burst end that is the current owner.
  assign w_base    = (r_state == BURST) ? r_owner : r_last_owner;
  assign w_start   = (w_base == LAST_IDX) ? '0 : w_base + OW'(1);
  assign w_mask    = w_abort ? w_owner_oh : '0;
  assign w_pick_oh = NREQ'(1) << w_pick_idx;

  rr_picker #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_picker (
    .req   (req),
    .mask  (w_mask),
    .start (w_start),
    .valid (w_pick_vld),
    .idx   (w_pick_idx)
  );

  // State, ownership, beat count and grant registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= LAST_IDX;
      r_beat_cnt   <= '0;
      r_gnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_gnt        <= w_gnt_nxt;
    end
  end

  // Next-state: grant on any request in IDLE; count beats and re-arbitrate at burst end.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_gnt_nxt        = r_gnt;
    case (r_state)
      IDLE: begin
        w_gnt_nxt = '0;
        if (w_pick_vld) begin
          w_state_nxt    = BURST;
          w_owner_nxt    = w_pick_idx;
          w_gnt_nxt      = w_pick_oh;
          w_beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + CW'(1);
        end
        if (w_end) begin
          w_last_owner_nxt = r_owner;
          w_beat_cnt_nxt   = '0;
          if (w_pick_vld) begin
            w_owner_nxt = w_pick_idx;
            w_gnt_nxt   = w_pick_oh;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  assign gnt        = r_gnt;
  assign busy       = (r_state == BURST);
  assign ack        = w_xfer ? w_owner_oh : '0;
  assign fifo_wr_en = w_xfer;
  assign fifo_din   = w_xfer ? w_din[r_owner] : '0;

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Scoreboard bench for sync_fifo_wr_arbiter: directed scenarios plus random traffic.
module tb_sync_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int unsigned N  = NREQ_DEF;
  localparam int unsigned DW = 16;
  localparam int unsigned MB = MAX_BURST_DEF;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*DW-1:0] din_flat;
  logic            fifo_full;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic            busy;

  sync_fifo_wr_arbiter #(
    .NREQ      (N),
    .DWIDTH    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .last       (last),
    .din_flat   (din_flat),
    .fifo_full  (fifo_full),
    .gnt        (gnt),
    .ack        (ack),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [N-1:0] ack;
    logic         wr;
    logic         busy;
  } cyc_t;

  cyc_t          cyc_q[$];
  logic [DW-1:0] data_q[$];
  int            total = 0;
  int            bad   = 0;

  // Reference model state: who owns the port and how many beats it has written.
  bit           m_busy;
  int           m_owner;
  int           m_last;
  int           m_beats;
  logic [N-1:0] exp_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int start, input int excl);
    logic [N-1:0] sh;
    int c;
    for (int k = 0; k < int'(N); k++) begin
      c  = (start + k) % int'(N);
      sh = r >> c;
      if (sh[0] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = int'(N) - 1;
    m_beats = 0;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, then advance one clock.
  task automatic model_step();
    cyc_t         e;
    logic [N-1:0] sh;
    logic         own_req;
    logic         own_last;
    logic         xfer;
    int           w;
    sh       = req >> m_owner;
    own_req  = sh[0];
    sh       = last >> m_owner;
    own_last = sh[0];
    xfer     = m_busy && own_req && !fifo_full;
    e.gnt    = m_busy ? (N'(1) << m_owner) : '0;
    e.ack    = xfer ? e.gnt : '0;
    e.wr     = xfer;
    e.busy   = m_busy;
    exp_ack  = e.ack;
    cyc_q.push_back(e);
    if (xfer) data_q.push_back(DW'(32'hA000 + m_owner));
    if (!m_busy) begin
      if (req != '0) begin
        m_owner = rr_pick(req, (m_last + 1) % int'(N), -1);
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else begin
      if (xfer) m_beats++;
      if (!own_req || (xfer && (own_last || m_beats == int'(MB)))) begin
        w       = rr_pick(req, (m_owner + 1) % int'(N), own_req ? -1 : m_owner);
        m_last  = m_owner;
        m_beats = 0;
        if (w >= 0) m_owner = w;
        else        m_busy  = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic f);
    @(negedge clk);
    req       = r;
    last      = l;
    fifo_full = f;
    #1;
    model_step();
  endtask

  // Monitor: compare every predicted cycle against what the DUT presents.
  initial begin
    cyc_t e;
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("gnt",   32'(gnt),        32'(e.gnt));
        chk("ack",   32'(ack),        32'(e.ack));
        chk("wr_en", 32'(fifo_wr_en), 32'(e.wr));
        chk("busy",  32'(busy),       32'(e.busy));
        if (e.wr) chk("din", 32'(fifo_din), 32'(data_q.pop_front()));
        else      chk("din_idle", 32'(fifo_din), 32'h0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] l;
    logic         f;
    int           b;
    int           fc;
    bit           p_act [N];
    int           p_len [N];
    int           p_beat[N];

    rstn      = 1'b0;
    req       = '0;
    last      = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      din_flat[i*DW +: DW] = DW'(32'hA000 + i);
      p_act[i]  = 1'b0;
      p_len[i]  = 1;
      p_beat[i] = 0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt",   32'(gnt),        32'h0);
    chk("rst_busy",  32'(busy),       32'h0);
    chk("rst_ack",   32'(ack),        32'h0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("rst_din",   32'(fifo_din),   32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // All requesting single-beat bursts: grant rotates 0,1,2,3,0.
    repeat (6) cycle(4'b1111, 4'b1111, 1'b0);
    repeat (2) cycle(4'b0000, 4'b0000, 1'b0);

    // Six-beat burst from requester 1 is split by the beat limit and regranted without a gap.
    b = 0;
    for (int k = 0; k < 30 && b < 6; k++) begin
      cycle(4'b0010, (b == 5) ? 4'b0010 : 4'b0000, 1'b0);
      if (exp_ack[1]) b++;
    end
    chk("t2_beats_done", 32'(b), 32'd6);
    repeat (2) cycle(4'b0000, 4'b0000, 1'b0);

    // Requester 2 stalls for three full cycles after its first beat.
    b  = 0;
    fc = 0;
    for (int k = 0; k < 40 && b < 5; k++) begin
      f = (b == 1) && (fc < 3);
      if (f) fc++;
      cycle(4'b0100, (b == 4) ? 4'b0100 : 4'b0000, f);
      if (exp_ack[2]) b++;
    end
    chk("t3_beats_done", 32'(b), 32'd5);
    repeat (2) cycle(4'b0000, 4'b0000, 1'b0);

    // Requester 0 aborts after one beat; requester 3 takes over next cycle.
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b1001, 4'b0000, 1'b0);
    cycle(4'b1000, 4'b0000, 1'b0);
    cycle(4'b1000, 4'b1000, 1'b0);
    repeat (2) cycle(4'b0000, 4'b0000, 1'b0);

    // Asynchronous reset pulse in the middle of a burst.
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0);
    #2;
    rstn = 1'b0;
    req  = '0;
    last = '0;
    #1;
    chk("arst_gnt",   32'(gnt),        32'h0);
    chk("arst_busy",  32'(busy),       32'h0);
    chk("arst_wr_en", 32'(fifo_wr_en), 32'h0);
    rstn = 1'b1;
    model_reset();
    repeat (2) cycle(4'b1000, 4'b1000, 1'b0);
    repeat (2) cycle(4'b0000, 4'b0000, 1'b0);

    // Random producers with random bursts, aborts and FIFO back-pressure.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!p_act[i]) begin
          if ($urandom_range(2) == 0) begin
            p_act[i]  = 1'b1;
            p_len[i]  = int'($urandom_range(6, 1));
            p_beat[i] = 0;
          end
        end else if ($urandom_range(15) == 0) begin
          p_act[i] = 1'b0;
        end
        r[i] = p_act[i];
        l[i] = p_act[i] && (p_beat[i] == p_len[i] - 1);
      end
      f = ($urandom_range(3) == 0);
      cycle(r, l, f);
      for (int i = 0; i < int'(N); i++) begin
        if (p_act[i] && exp_ack[i]) begin
          p_beat[i]++;
          if (p_beat[i] == p_len[i]) p_act[i] = 1'b0;
        end
      end
    end
    repeat (3) cycle(4'b0000, 4'b0000, 1'b0);

    repeat (2) @(negedge clk);
    #3;
    chk("queues_drained", 32'(cyc_q.size() + data_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
